seq_right_shifter_16bit: RTL
============================

Name: seq_right_shifter_16bit

Overview:
- Multi-cycle, iterative right shifter/rotator.
- Complements the combinational left barrel shifter: same in/ctrl/out data interface, opposite direction.
- Shifts one bit per clock under a start/done handshake.
- Used where area matters more than latency, and as a cross-check source for the barrel shifter in system benches.

Parameters:
- WIDTH, 16, data width in bits.
- CW, 4, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled on the rising edge.
- in  input  WIDTH  operand; captured when start is accepted.
- ctrl  input  CW  shift amount 0..WIDTH-1; captured with in.
- mode  input  2  00 logical right, 01 arithmetic right, 10 rotate right, 11 reserved (behaves as 00); captured with in.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; out is valid from this cycle onward.
- out  output  WIDTH  result; held until the next result is written.

Behaviour:
- Reset (rst=1 at an edge):
  - state <= IDLE; busy, done, out, internal data and count registers all <= 0.
  - Reset overrides start and any in-flight operation; an aborted result never reaches out.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at edge E: data <= in, count <= ctrl, mode latched, state <= SHIFT.
- SHIFT (busy=1, done=0), at each edge:
  - count != 0: data shifted right by 1 per latched mode, count <= count-1.
  - count == 0: out <= data, state <= DONE.
  - start is ignored while in SHIFT.
- DONE:
  - done=1, busy=0, for exactly one cycle.
  - Next edge: start=1 accepts a new operation exactly as in IDLE (back-to-back allowed); otherwise state <= IDLE.
- Latency: start accepted at edge E, out updated and done high at edge E+ctrl+1.
  - ctrl=0 gives out=in at edge E+1.
  - Minimum issue interval is ctrl+2 cycles.
- Shift rules per step:
  - logical: MSB <= 0.
  - arithmetic: MSB <= old MSB (sign replicated).
  - rotate: MSB <= old LSB.
  - No bit is lost in rotate mode; shifting by ctrl is equivalent to ctrl single steps.
- Inputs in, ctrl and mode are don't-care except when start is accepted; changes mid-operation have no effect.
- out changes only at the DONE transition or at reset.
- ctrl is at most WIDTH-1 by width, so there is no over-shift case.

Test Plan:
- Reset, then in=16'd128, ctrl=4, mode=00, start 1 cycle -> busy high 5 cycles, done at edge E+5, out=16'd8.
- in=16'h8000, ctrl=15, mode=01 -> done at E+16, out=16'hFFFF; then in=16'h4000, ctrl=15, mode=01 -> out=16'h0000.
- in=16'h0001, ctrl=1, mode=10 -> out=16'h8000; then in=16'hA5A5, ctrl=0, mode=10 -> done at E+1, out=16'hA5A5.
- Start in=16'hF000, ctrl=8, mode=00; pulse start again with in=16'hFFFF, ctrl=0 at E+3 -> second request ignored, out=16'h00F0 at E+9. Then assert start in the DONE cycle with in=16'h0100, ctrl=8 -> accepted, out=16'h0001 nine cycles later.
- Start in=16'h1234, ctrl=10; assert rst at E+4 -> next edge busy=0, done=0, out=16'h0000; done never pulses for the aborted operation.
- mode=11, in=16'h8001, ctrl=1 -> out=16'h4000 (same as logical).

Source files
------------

// File: rtl/seq_right_shifter_16bit.sv
`default_nettype none
// ============================================================================
// Module   : seq_right_shifter_16bit
// Purpose  : Iterative right shifter / rotator. Shifts one bit position per
//            clock under a start/done handshake. Supports logical right,
//            arithmetic right and rotate right. Mode 11 behaves as logical.
// Ports    : clk   - system clock (rising edge)
//            rst   - synchronous active-high reset
//            start - request pulse, sampled on the rising edge
//            in    - operand, captured when start is accepted
//            ctrl  - shift amount 0..WIDTH-1, captured with in
//            mode  - 00 lsr, 01 asr, 10 ror, 11 lsr; captured with in
//            busy  - high while an operation is in progress
//            done  - one-cycle pulse; out valid from this cycle onward
//            out   - result, held until the next result is written
// Revision : 1.0 - initial release
// ============================================================================
module seq_right_shifter_16bit #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [CW-1:0]    ctrl,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [1:0] c_MODE_ASR = 2'b01;
    localparam logic [1:0] c_MODE_ROR = 2'b10;

    localparam logic [CW-1:0] c_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_count;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_step;
    logic             w_accept;

    // Bit shifted into the MSB on each single-position step.
    always_comb begin
        w_step = {1'b0, r_data[WIDTH-1:1]};
        case (r_mode)
            c_MODE_ASR: w_step = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
            c_MODE_ROR: w_step = {r_data[0],       r_data[WIDTH-1:1]};
            default:    w_step = {1'b0,            r_data[WIDTH-1:1]};
        endcase
    end

    // A new request is taken from IDLE or directly from DONE (back-to-back).
    assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_data  <= '0;
            r_count <= '0;
            r_mode  <= 2'b00;
            r_out   <= '0;
        end else begin
            case (r_state)
                c_SHIFT: begin
                    if (r_count != '0) begin
                        r_data  <= w_step;
                        r_count <= r_count - c_ONE;
                    end else begin
                        r_out   <= r_data;
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE share the same accept behaviour.
                    if (w_accept) begin
                        r_data  <= in;
                        r_count <= ctrl;
                        r_mode  <= mode;
                        r_state <= c_SHIFT;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = (r_state == c_SHIFT);
    assign done = (r_state == c_DONE);
    assign out  = r_out;

endmodule
`default_nettype wire
